// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 scan-code receiver:
//   - ps2_state_e : frame reception FSM encoding
//   - EXT_PREFIX  : 8'hE0, marks the following code as extended
//   - REL_PREFIX  : 8'hF0, marks the following code as a key release
//   - ENTRY_W     : width of one buffered entry {extended, release, code}
//   - odd_parity_ok() : odd-parity check over data byte plus parity bit
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] EXT_PREFIX = 8'hE0;
  localparam logic [7:0] REL_PREFIX = 8'hF0;
  localparam int         ENTRY_W    = 10;

  // True when data plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ((^{data, par}) == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// ---------------------------------------------------------------------------
// ps2_sync_fifo
// Single-clock show-ahead FIFO. The head entry is presented whenever the
// FIFO is non-empty and is removed by pop. A push while full succeeds only
// when a pop happens in the same cycle; otherwise it is dropped and flagged.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write request and entry
//   pop              remove head (ignored when empty)
//   head             head entry (zero when empty)
//   valid            FIFO non-empty
//   count            entries held
//   dropped          one-cycle flag: push discarded because FIFO was full
// ---------------------------------------------------------------------------
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         dropped
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             empty_s;
  logic             full_s;
  logic             do_pop_s;
  logic             do_push_s;

  // Decide which requests actually take effect this cycle
  always_comb begin
    empty_s   = (count_r == {CW{1'b0}});
    full_s    = (count_r == CNT_FULL);
    do_pop_s  = pop && !empty_s;
    do_push_s = push && (!full_s || do_pop_s);
  end

  // Storage array, written on accepted push only
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign valid   = !empty_s;
  assign count   = count_r;
  assign head    = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign dropped = push && !do_push_s;

endmodule

// File: rtl/ps2_scan_receiver.sv
// ---------------------------------------------------------------------------
// ps2_scan_receiver
// Receives PS/2 device frames (start, 8 data LSB first, odd parity, stop),
// folds 0xE0 / 0xF0 prefixes into flags and buffers decoded entries in a
// show-ahead FIFO.
// Optional build macro: PS2_PARITY_CHECK_EN -- when defined, frames with a
// parity failure are discarded and parity_err pulses; otherwise the parity
// bit is consumed and ignored and parity_err is tied low.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   ps2_clk, ps2_data     asynchronous PS/2 lines from the device
//   code                  scan code of the FIFO head entry
//   extended, release_key head entry was preceded by 0xE0 / 0xF0
//   out_valid, out_ready  head valid / consumer accepts head
//   fifo_count            entries held
//   frame_err             pulse: bad stop bit or timeout abort
//   parity_err            pulse: parity failure (macro builds only)
//   overflow              sticky: an entry was dropped on a full FIFO
// ---------------------------------------------------------------------------
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ps2_clk,
  input  logic                              ps2_data,
  output logic [7:0]                        code,
  output logic                              extended,
  output logic                              release_key,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              overflow
);

  localparam int LW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LW-1:0] LOW_LAST = LW'(FILTER_LEN - 1);
  localparam logic [LW-1:0] LOW_ONE  = LW'(1'b1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1'b1);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   clk_s;
  logic                   data_s;

  logic [LW-1:0]          low_cnt_r;
  logic                   armed_r;
  logic                   edge_s;

  ps2_state_e             state_r, state_n;
  logic [2:0]             bit_cnt_r, bit_cnt_n;
  logic [7:0]             shift_r, shift_n;
  logic [TW-1:0]          timer_r;
  logic                   timeout_s;
  logic                   accept_s;
  logic                   ferr_s;

  logic                   accept_r;
  logic [7:0]             byte_r;
  logic                   frame_err_r;
  logic                   ext_r;
  logic                   rel_r;
  logic                   overflow_r;

  logic                   push_s;
  logic [ENTRY_W-1:0]     push_data_s;
  logic [ENTRY_W-1:0]     head_s;
  logic                   dropped_s;

`ifdef PS2_PARITY_CHECK_EN
  logic                   par_r, par_n;
  logic                   perr_s;
  logic                   parity_err_r;
`endif

  // Synchronise both PS/2 lines; the idle level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r  <= {SYNC_STAGES{1'b1}};
      data_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync_r[SYNC_STAGES-1];
  assign data_s = data_sync_r[SYNC_STAGES-1];

  // Glitch filter: a high level arms the detector, the FILTER_LEN-th low sample fires once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt_r <= {LW{1'b0}};
      armed_r   <= 1'b1;
    end else if (clk_s) begin
      low_cnt_r <= {LW{1'b0}};
      armed_r   <= 1'b1;
    end else begin
      if (low_cnt_r != LOW_LAST) begin
        low_cnt_r <= low_cnt_r + LOW_ONE;
      end
      if (edge_s) begin
        armed_r <= 1'b0;
      end
    end
  end

  assign edge_s    = armed_r && !clk_s && (low_cnt_r == LOW_LAST);
  assign timeout_s = (state_r != ST_IDLE) && !edge_s && (timer_r == TMO_LAST);

  // Frame FSM next state and per-frame verdicts
  always_comb begin
    state_n   = state_r;
    bit_cnt_n = bit_cnt_r;
    shift_n   = shift_r;
    accept_s  = 1'b0;
    ferr_s    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_n     = par_r;
    perr_s    = 1'b0;
`endif
    if (timeout_s) begin
      state_n = ST_IDLE;
      ferr_s  = 1'b1;
    end else if (edge_s) begin
      case (state_r)
        ST_IDLE: begin
          // A high start bit is noise; wait for a real one
          if (!data_s) begin
            state_n   = ST_DATA;
            bit_cnt_n = 3'd0;
          end else begin
            state_n   = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_n = {data_s, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_n = ST_PARITY;
          end else begin
            bit_cnt_n = bit_cnt_r + 3'd1;
          end
        end
        ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_n   = data_s;
`endif
          state_n = ST_STOP;
        end
        ST_STOP: begin
          state_n = ST_IDLE;
          if (!data_s) begin
            ferr_s = 1'b1;
          end else begin
`ifdef PS2_PARITY_CHECK_EN
            if (!odd_parity_ok(shift_r, par_r)) begin
              perr_s = 1'b1;
            end else begin
              accept_s = 1'b1;
            end
`else
            accept_s = 1'b1;
`endif
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // FSM state, bit counter, shift register and inactivity timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      timer_r   <= {TW{1'b0}};
    end else begin
      state_r   <= state_n;
      bit_cnt_r <= bit_cnt_n;
      shift_r   <= shift_n;
      if (edge_s || (state_r == ST_IDLE)) begin
        timer_r <= {TW{1'b0}};
      end else begin
        timer_r <= timer_r + TMO_ONE;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  // Captured parity bit and the registered parity error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_r        <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      par_r        <= par_n;
      parity_err_r <= perr_s;
    end
  end

  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

  // Registered verdict of the frame just closed by its stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_r    <= 1'b0;
      byte_r      <= 8'h00;
      frame_err_r <= 1'b0;
    end else begin
      accept_r    <= accept_s;
      frame_err_r <= ferr_s;
      if (accept_s) begin
        byte_r <= shift_r;
      end
    end
  end

  // Prefix flags: set by 0xE0 / 0xF0, cleared when a real code is pushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_r <= 1'b0;
      rel_r <= 1'b0;
    end else if (accept_r) begin
      if (byte_r == EXT_PREFIX) begin
        ext_r <= 1'b1;
      end else if (byte_r == REL_PREFIX) begin
        rel_r <= 1'b1;
      end else begin
        ext_r <= 1'b0;
        rel_r <= 1'b0;
      end
    end
  end

  assign push_s      = accept_r && (byte_r != EXT_PREFIX) && (byte_r != REL_PREFIX);
  assign push_data_s = {ext_r, rel_r, byte_r};

  ps2_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (out_ready),
    .head      (head_s),
    .valid     (out_valid),
    .count     (fifo_count),
    .dropped   (dropped_s)
  );

  // Sticky overflow, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (dropped_s) begin
      overflow_r <= 1'b1;
    end
  end

  assign code        = head_s[7:0];
  assign release_key = head_s[8];
  assign extended    = head_s[9];
  assign frame_err   = frame_err_r;
  assign overflow    = overflow_r;

endmodule
